dbus_arbiter: RTL

- Two-master arbiter for the shared data bus (read/write address, data, mode) in front of the busdev-decoded peripherals: data memory, GPIO and terminal.
- Master 0 is the core data port; master 1 is the debug interface, used for memory peek/poke over UART.
- Round-robin grant; one transaction in flight at a time. Request fields are latched at grant, and a timeout counter recovers from slaves that never acknowledge.

---
 rtl/dbus_arbiter_if.sv | 35 +++
 rtl/dbus_arbiter.sv | 126 ++++++++++++
 2 files changed

// File: rtl/dbus_arbiter_if.sv
// Shared data-bus bundle: both master request/response channels plus the slave-side bus.
// The arbiter uses the master modport because it masters the peripheral bus; the slave modport is the environment's view.
interface dbus_arbiter_if;
    logic        m0_req, m1_req;
    logic        m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;
    logic [1:0]  m0_mode, m1_mode;
    logic        m0_gnt, m1_gnt;
    logic        m0_done, m1_done;
    logic        m0_err, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        bus_r_en, bus_w_en;
    logic [31:0] bus_r_addr, bus_w_addr;
    logic [1:0]  bus_r_mode, bus_w_mode;
    logic [31:0] bus_w_data;
    logic [31:0] bus_r_data;
    logic        bus_ack;

    modport master (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_mode, m1_mode, bus_r_data, bus_ack,
        output m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err,
               m0_rdata, m1_rdata, bus_r_en, bus_w_en, bus_r_addr, bus_w_addr,
               bus_r_mode, bus_w_mode, bus_w_data
    );

    modport slave (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr,
               m0_wdata, m1_wdata, m0_mode, m1_mode, bus_r_data, bus_ack,
        input  m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err,
               m0_rdata, m1_rdata, bus_r_en, bus_w_en, bus_r_addr, bus_w_addr,
               bus_r_mode, bus_w_mode, bus_w_data
    );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master round-robin arbiter for the shared data bus, one transaction in flight,
// with a saturating timeout that completes the transfer with err when no slave acknowledges.
module dbus_arbiter #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input logic           clk,
    input logic           rst,
    dbus_arbiter_if.master bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic             last_owner, owner, t_we;
    logic [CNT_W-1:0] cnt;

    logic        pick_valid, pick, sel_we;
    logic [31:0] sel_addr, sel_wdata;
    logic [1:0]  sel_mode;

    // On a tie the master that did not own the last transaction wins.
    always_comb begin
        pick_valid = bus.m0_req | bus.m1_req;
        pick       = (bus.m0_req && bus.m1_req) ? ~last_owner : bus.m1_req;
        sel_we     = pick ? bus.m1_we    : bus.m0_we;
        sel_addr   = pick ? bus.m1_addr  : bus.m0_addr;
        sel_wdata  = pick ? bus.m1_wdata : bus.m0_wdata;
        sel_mode   = pick ? bus.m1_mode  : bus.m0_mode;
    end

    logic        finish;
    logic [31:0] cap_data;

    always_comb begin
        finish   = bus.bus_ack || (cnt == CNT_MAX);
        cap_data = (bus.bus_ack && !t_we) ? bus.bus_r_data : 32'h0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_owner     <= 1'b1;
            owner          <= 1'b0;
            t_we           <= 1'b0;
            cnt            <= '0;
            bus.m0_gnt     <= 1'b0;
            bus.m1_gnt     <= 1'b0;
            bus.m0_done    <= 1'b0;
            bus.m1_done    <= 1'b0;
            bus.m0_err     <= 1'b0;
            bus.m1_err     <= 1'b0;
            bus.m0_rdata   <= '0;
            bus.m1_rdata   <= '0;
            bus.bus_r_en   <= 1'b0;
            bus.bus_w_en   <= 1'b0;
            bus.bus_r_addr <= '0;
            bus.bus_w_addr <= '0;
            bus.bus_r_mode <= '0;
            bus.bus_w_mode <= '0;
            bus.bus_w_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner      <= pick;
                        t_we       <= sel_we;
                        cnt        <= '0;
                        bus.m0_gnt <= ~pick;
                        bus.m1_gnt <= pick;
                        // The bus registers double as the transaction register.
                        if (sel_we) begin
                            bus.bus_w_en   <= 1'b1;
                            bus.bus_w_addr <= sel_addr;
                            bus.bus_w_data <= sel_wdata;
                            bus.bus_w_mode <= sel_mode;
                        end else begin
                            bus.bus_r_en   <= 1'b1;
                            bus.bus_r_addr <= sel_addr;
                            bus.bus_r_mode <= sel_mode;
                        end
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (finish) begin
                        bus.bus_r_en   <= 1'b0;
                        bus.bus_w_en   <= 1'b0;
                        bus.bus_r_addr <= '0;
                        bus.bus_w_addr <= '0;
                        bus.bus_r_mode <= '0;
                        bus.bus_w_mode <= '0;
                        bus.bus_w_data <= '0;
                        if (owner) begin
                            bus.m1_done  <= 1'b1;
                            bus.m1_err   <= ~bus.bus_ack;
                            bus.m1_rdata <= cap_data;
                        end else begin
                            bus.m0_done  <= 1'b1;
                            bus.m0_err   <= ~bus.bus_ack;
                            bus.m0_rdata <= cap_data;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    bus.m0_gnt   <= 1'b0;
                    bus.m1_gnt   <= 1'b0;
                    bus.m0_done  <= 1'b0;
                    bus.m1_done  <= 1'b0;
                    bus.m0_err   <= 1'b0;
                    bus.m1_err   <= 1'b0;
                    bus.m0_rdata <= '0;
                    bus.m1_rdata <= '0;
                    last_owner   <= owner;
                    cnt          <= '0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
